inst_axi_bridge: RTL and testbench

Instruction-side bus bridge sitting directly upstream of `if_stage`. It accepts fetch requests on the split address/data handshake (`inst_addr_ok` / `inst_data_ok`), issues single-beat 64-bit AXI4 read bursts, and returns each aligned doubleword in request order. `if_stage` selects the 32-bit half itself using `pc[2]`.

---
 rtl/inst_axi_bridge_pkg.sv | 21 ++
 rtl/axi_ar_slot.sv | 46 ++++
 rtl/inst_axi_bridge.sv | 130 +++++++++++++
 tb/tb_inst_axi_bridge.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_axi_bridge_pkg.sv
// Shared constants and helpers for the instruction-side AXI bridge.
// Kept in one package so the data-side bridge can reuse the same values.
package inst_axi_bridge_pkg;

    localparam int REG_BUS = 64;

    typedef logic [REG_BUS-1:0] reg_bus_t;

    localparam reg_bus_t   ZERO_WORD      = 64'h0000_0000_0000_0000;
    localparam reg_bus_t   DWORD_MASK     = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'h00;

    // Round a byte address down to the doubleword that contains it.
    function automatic reg_bus_t align_dword(input reg_bus_t addr);
        return addr & DWORD_MASK;
    endfunction

endpackage

// File: rtl/axi_ar_slot.sv
// Single-entry AXI read-address slot: latches an address on load and holds
// ar_valid/ar_addr stable until the slave accepts it.
module axi_ar_slot #(
    parameter int AW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic          ar_ready,
    output logic          ar_valid,
    output logic [AW-1:0] ar_addr
);

    logic          ar_valid_d, ar_valid_q;
    logic [AW-1:0] ar_addr_d,  ar_addr_q;

    // Next-state: load a new address, retire on handshake, otherwise hold.
    always_comb begin
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        if (load_en) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = load_addr;
        end else if (ar_valid_q && ar_ready) begin
            ar_valid_d = 1'b0;
        end else begin
            ar_valid_d = ar_valid_q;
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= {AW{1'b0}};
        end else begin
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
        end
    end

    assign ar_valid = ar_valid_q;
    assign ar_addr  = ar_addr_q;

endmodule

// File: rtl/inst_axi_bridge.sv
// Instruction-side bridge: turns split addr_ok/data_ok fetch requests into
// single-beat 64-bit AXI4 reads and returns doublewords in request order.
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic        if_req_op,
    input  logic [63:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [63:0] inst_data,
    output logic        bus_err,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [63:0] ar_addr,
    output logic [3:0]  ar_id,
    output logic [7:0]  ar_len,
    output logic [2:0]  ar_size,
    output logic [1:0]  ar_burst,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [63:0] r_data,
    input  logic [1:0]  r_resp,
    input  logic        r_last,
    input  logic [3:0]  r_id
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    logic [1:0] cnt_d,      cnt_q;
    logic       data_ok_d,  data_ok_q;
    reg_bus_t   data_d,     data_q;
    logic       bus_err_d,  bus_err_q;
    logic       r_ready_d,  r_ready_q;

    logic       addr_ok_s;
    logic       illegal_s;
    logic       r_match_s;
    logic       ar_valid_s;

    // Acceptance is combinational; one AR slot means no accept while it is busy.
    assign addr_ok_s = rst & if_req_valid & ~if_req_op & ~ar_valid_s & (cnt_q < MAX_CNT);
    assign illegal_s = if_req_valid & if_req_op;
    // Only beats carrying our ID are returned; foreign beats are consumed and dropped.
    assign r_match_s = r_valid & r_ready_q & (r_id == AXI_ID);

    axi_ar_slot #(
        .AW(REG_BUS)
    ) u_ar_slot (
        .clk      (clk),
        .rst      (rst),
        .load_en  (addr_ok_s),
        .load_addr(align_dword(inst_addr)),
        .ar_ready (ar_ready),
        .ar_valid (ar_valid_s),
        .ar_addr  (ar_addr)
    );

    // Outstanding count, response capture and sticky error.
    always_comb begin
        cnt_d     = cnt_q;
        data_d    = data_q;
        data_ok_d = 1'b0;
        bus_err_d = bus_err_q;

        case ({addr_ok_s, data_ok_q})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        if (r_match_s) begin
            data_ok_d = 1'b1;
            if (r_resp != AXI_RESP_OKAY) begin
                data_d = ZERO_WORD;
            end else begin
                data_d = r_data;
            end
            if ((r_resp != AXI_RESP_OKAY) || !r_last) begin
                bus_err_d = 1'b1;
            end else begin
                bus_err_d = bus_err_q;
            end
        end else begin
            data_ok_d = 1'b0;
        end

        if (illegal_s) begin
            bus_err_d = 1'b1;
        end else begin
            bus_err_d = bus_err_d;
        end

        r_ready_d = (cnt_d != 2'd0);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= 2'd0;
            data_ok_q <= 1'b0;
            data_q    <= ZERO_WORD;
            bus_err_q <= 1'b0;
            r_ready_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            data_ok_q <= data_ok_d;
            data_q    <= data_d;
            bus_err_q <= bus_err_d;
            r_ready_q <= r_ready_d;
        end
    end

    assign inst_addr_ok = addr_ok_s;
    assign inst_data_ok = data_ok_q;
    assign inst_data    = data_q;
    assign bus_err      = bus_err_q;
    assign ar_valid     = ar_valid_s;
    assign ar_id        = AXI_ID;
    assign ar_len       = AXI_LEN_SINGLE;
    assign ar_size      = AXI_SIZE_8B;
    assign ar_burst     = AXI_BURST_INCR;
    assign r_ready      = r_ready_q;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge; the bench itself plays the AXI slave.
module tb_inst_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_op;
    logic [63:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_data;
    logic        bus_err;
    logic        ar_valid;
    logic        ar_ready;
    logic [63:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_id;

    int errors = 0;
    int checks = 0;
    int pulses;

    always #5 clk = ~clk;

    inst_axi_bridge #(
        .MAX_OUTSTANDING(2),
        .AXI_ID         (4'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_valid(if_req_valid),
        .if_req_op   (if_req_op),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_data   (inst_data),
        .bus_err     (bus_err),
        .ar_valid    (ar_valid),
        .ar_ready    (ar_ready),
        .ar_addr     (ar_addr),
        .ar_id       (ar_id),
        .ar_len      (ar_len),
        .ar_size     (ar_size),
        .ar_burst    (ar_burst),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data),
        .r_resp      (r_resp),
        .r_last      (r_last),
        .r_id        (r_id)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic r_beat(input logic [63:0] d, input logic [1:0] resp, input logic [3:0] id);
        r_valid = 1'b1;
        r_data  = d;
        r_resp  = resp;
        r_last  = 1'b1;
        r_id    = id;
    endtask

    initial begin
        rst = 1'b0; if_req_valid = 1'b1; if_req_op = 1'b0; inst_addr = 64'h0;
        ar_ready = 1'b1; r_valid = 1'b0; r_data = 64'h0; r_resp = 2'b00;
        r_last = 1'b1; r_id = 4'd0;

        // ---------------- reset state ----------------
        step(); step();
        #1;
        check("rst_addr_ok", 64'(inst_addr_ok), 64'd0);
        check("rst_data_ok", 64'(inst_data_ok), 64'd0);
        check("rst_data",    inst_data,         64'd0);
        check("rst_bus_err", 64'(bus_err),      64'd0);
        check("rst_ar_valid",64'(ar_valid),     64'd0);
        check("rst_ar_addr", ar_addr,           64'd0);
        check("rst_r_ready", 64'(r_ready),      64'd0);
        check("ar_len",      64'(ar_len),       64'd0);
        check("ar_size",     64'(ar_size),      64'd3);
        check("ar_burst",    64'(ar_burst),     64'd1);
        check("ar_id",       64'(ar_id),        64'd0);
        step();

        // ---------------- single fetch ----------------
        rst = 1'b1; if_req_valid = 1'b1; inst_addr = 64'h0000_0000_8000_0004;
        #1;
        check("sf_addr_ok_c0", 64'(inst_addr_ok), 64'd1);
        step();
        if_req_valid = 1'b0;
        #1;
        check("sf_ar_valid_c1", 64'(ar_valid), 64'd1);
        check("sf_ar_addr_c1",  ar_addr, 64'h0000_0000_8000_0000);
        check("sf_r_ready_c1",  64'(r_ready), 64'd1);
        check("sf_data_ok_c1",  64'(inst_data_ok), 64'd0);
        step();
        r_beat(64'h1111_2222_3333_4444, 2'b00, 4'd0);
        #1;
        check("sf_ar_valid_c2", 64'(ar_valid), 64'd0);
        check("sf_data_ok_c2",  64'(inst_data_ok), 64'd0);
        step();
        r_valid = 1'b0;
        #1;
        check("sf_data_ok_c3", 64'(inst_data_ok), 64'd1);
        check("sf_data_c3",    inst_data, 64'h1111_2222_3333_4444);
        step();
        #1;
        check("sf_data_ok_c4", 64'(inst_data_ok), 64'd0);
        check("sf_data_hold",  inst_data, 64'h1111_2222_3333_4444);
        check("sf_r_ready_c4", 64'(r_ready), 64'd0);

        // ---------------- outstanding limit ----------------
        if_req_valid = 1'b1; inst_addr = 64'h0000_0000_0000_1000;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (inst_addr_ok) pulses++;
            step();
        end
        check("lim_pulses", 64'(pulses), 64'd2);
        check("lim_r_ready", 64'(r_ready), 64'd1);
        r_beat(64'hAAAA_0000_0000_0001, 2'b00, 4'd0);
        #1;
        check("lim_blocked", 64'(inst_addr_ok), 64'd0);
        step();
        r_valid = 1'b0;
        #1;
        check("lim_data_ok",  64'(inst_data_ok), 64'd1);
        check("lim_still_blk",64'(inst_addr_ok), 64'd0);
        check("lim_data",     inst_data, 64'hAAAA_0000_0000_0001);
        step();
        #1;
        check("lim_resume", 64'(inst_addr_ok), 64'd1);
        if_req_valid = 1'b0;
        r_beat(64'hAAAA_0000_0000_0002, 2'b00, 4'd0);
        step();
        r_valid = 1'b0;
        #1;
        check("lim_data2_ok", 64'(inst_data_ok), 64'd1);
        check("lim_data2",    inst_data, 64'hAAAA_0000_0000_0002);
        step();
        #1;
        check("lim_drained", 64'(r_ready), 64'd0);

        // ---------------- AR backpressure ----------------
        ar_ready = 1'b0; if_req_valid = 1'b1; inst_addr = 64'h0000_0000_2000_001C;
        #1;
        check("bp_accept", 64'(inst_addr_ok), 64'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ar_valid", 64'(ar_valid), 64'd1);
            check("bp_ar_addr",  ar_addr, 64'h0000_0000_2000_0018);
            check("bp_no_accept",64'(inst_addr_ok), 64'd0);
            step();
        end
        ar_ready = 1'b1; if_req_valid = 1'b0;
        #1;
        check("bp_hs_valid", 64'(ar_valid), 64'd1);
        step();
        #1;
        check("bp_ar_cleared", 64'(ar_valid), 64'd0);

        // ---------------- foreign ID then error response ----------------
        r_beat(64'h5555_5555_5555_5555, 2'b00, 4'd5);
        step();
        r_valid = 1'b0;
        #1;
        check("foreign_no_data_ok", 64'(inst_data_ok), 64'd0);
        check("foreign_r_ready",    64'(r_ready), 64'd1);
        r_beat(64'hDEAD_BEEF_DEAD_BEEF, 2'b10, 4'd0);
        step();
        r_valid = 1'b0; r_resp = 2'b00;
        #1;
        check("err_data_ok", 64'(inst_data_ok), 64'd1);
        check("err_data",    inst_data, 64'd0);
        check("err_bus_err", 64'(bus_err), 64'd1);
        step(); step(); step();
        #1;
        check("err_sticky", 64'(bus_err), 64'd1);

        // ---------------- illegal op ----------------
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("il_cleared", 64'(bus_err), 64'd0);
        if_req_valid = 1'b1; if_req_op = 1'b1; inst_addr = 64'h0000_0000_0000_3000;
        #1;
        check("il_addr_ok", 64'(inst_addr_ok), 64'd0);
        step();
        if_req_valid = 1'b0; if_req_op = 1'b0;
        #1;
        check("il_no_ar",   64'(ar_valid), 64'd0);
        check("il_bus_err", 64'(bus_err), 64'd1);

        // ---------------- reset mid-flight ----------------
        rst = 1'b0;
        step();
        rst = 1'b1; if_req_valid = 1'b1; inst_addr = 64'h0000_0000_0000_4000;
        step(); step(); step();
        #1;
        check("mf_pre_ar_valid", 64'(ar_valid), 64'd1);
        check("mf_pre_r_ready",  64'(r_ready), 64'd1);
        check("mf_pre_blocked",  64'(inst_addr_ok), 64'd0);
        rst = 1'b0;
        #1;
        check("mf_addr_ok_in_rst", 64'(inst_addr_ok), 64'd0);
        step();
        #1;
        check("mf_ar_valid", 64'(ar_valid), 64'd0);
        check("mf_ar_addr",  ar_addr, 64'd0);
        check("mf_r_ready",  64'(r_ready), 64'd0);
        check("mf_data_ok",  64'(inst_data_ok), 64'd0);
        check("mf_data",     inst_data, 64'd0);
        check("mf_bus_err",  64'(bus_err), 64'd0);
        rst = 1'b1;
        #1;
        check("mf_reaccept", 64'(inst_addr_ok), 64'd1);
        if_req_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
